// File: rtl/echo_feedback_mixer.sv
// Feedback/mix stage that closes the delay-line loop for an echo effect.
// Fixed-latency FSM: one sample in, one feedback write plus one output out.
module echo_feedback_mixer #(
    parameter int DATA_WIDTH  = 32,
    parameter int GAIN_WIDTH  = 16,
    parameter int TAP_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_sample,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  enable,
    input  logic [GAIN_WIDTH-1:0] fb_gain,
    input  logic [GAIN_WIDTH-1:0] mix,
    input  logic [DATA_WIDTH-1:0] dl_rd_sample,
    input  logic                  dl_rd_valid,
    output logic [DATA_WIDTH-1:0] dl_wr_sample,
    output logic                  dl_wr_valid,
    output logic [DATA_WIDTH-1:0] out_sample,
    output logic                  out_valid
);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam int CW = (TAP_LATENCY > 1) ? $clog2(TAP_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE,
        TAP_WAIT,
        MULT,
        SUM,
        OUT
    } state_t;

    state_t state, state_n;

    logic signed [DATA_WIDTH-1:0] dry, wet;
    logic [GAIN_WIDTH-1:0]        fb, mx;
    logic                         en;
    logic [CW-1:0]                cnt;
    logic signed [PW-1:0]         pf, pd, pw;

    logic signed [PW-1:0]         wet_x, dry_x, fb_x, mx_x, inv_x;
    logic [GAIN_WIDTH:0]          inv;
    logic signed [DATA_WIDTH:0]   fb_sum;
    logic [DATA_WIDTH-1:0]        fb_sat;
    logic signed [PW-1:0]         mix_sum;
    logic                         unused_bits;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (in_valid) state_n = TAP_WAIT;
            TAP_WAIT: if (cnt == '0) state_n = MULT;
            MULT:     state_n = SUM;
            SUM:      state_n = OUT;
            OUT:      state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Operands widened to the full product width so every product is exact.
    assign inv   = {1'b1, {GAIN_WIDTH{1'b0}}} - {1'b0, mx};
    assign wet_x = {{(PW-DATA_WIDTH){wet[DATA_WIDTH-1]}}, wet};
    assign dry_x = {{(PW-DATA_WIDTH){dry[DATA_WIDTH-1]}}, dry};
    assign fb_x  = {{(PW-GAIN_WIDTH){1'b0}}, fb};
    assign mx_x  = {{(PW-GAIN_WIDTH){1'b0}}, mx};
    assign inv_x = {{(PW-GAIN_WIDTH-1){1'b0}}, inv};

    // pf[PW-1:GAIN_WIDTH] is pf >>> GAIN_WIDTH at DATA_WIDTH+1 bits.
    assign fb_sum = {dry[DATA_WIDTH-1], dry} + pf[PW-1:GAIN_WIDTH];
    always_comb begin
        fb_sat = fb_sum[DATA_WIDTH-1:0];
        if (fb_sum[DATA_WIDTH] != fb_sum[DATA_WIDTH-1])
            fb_sat = fb_sum[DATA_WIDTH]
                   ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    assign mix_sum     = pd + pw;
    assign unused_bits = ^{pf[GAIN_WIDTH-1:0], mix_sum[GAIN_WIDTH-1:0],
                           mix_sum[PW-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            dry          <= '0;
            wet          <= '0;
            fb           <= '0;
            mx           <= '0;
            en           <= 1'b0;
            cnt          <= '0;
            pf           <= '0;
            pd           <= '0;
            pw           <= '0;
            dl_wr_sample <= '0;
            dl_wr_valid  <= 1'b0;
            out_sample   <= '0;
            out_valid    <= 1'b0;
        end else begin
            dl_wr_valid <= 1'b0;
            out_valid   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dry <= in_sample;
                        fb  <= fb_gain;
                        mx  <= mix;
                        en  <= enable;
                        cnt <= CW'(TAP_LATENCY - 1);
                    end
                end
                TAP_WAIT: begin
                    if (cnt == '0)
                        wet <= (dl_rd_valid && en) ? dl_rd_sample : '0;
                    else
                        cnt <= cnt - 1'b1;
                end
                MULT: begin
                    pf <= wet_x * fb_x;
                    pd <= dry_x * inv_x;
                    pw <= wet_x * mx_x;
                end
                SUM: begin
                    dl_wr_sample <= en ? fb_sat : '0;
                    out_sample   <= mix_sum[DATA_WIDTH+GAIN_WIDTH-1:GAIN_WIDTH];
                    dl_wr_valid  <= 1'b1;
                    out_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
